// File: rtl/shot_responder.sv
// Defending-side shot handler: ship/shot maps, per-shot result codes, hit counting, turn hand-back and a board read port.
// Shot-to-response is 2 cycles; the response is held until resp_ready, and no new shot is taken until then (shot_ready low).
module shot_responder #(
  parameter int SHIP_CELLS = 11
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       board_clear,
  input  logic       armed,
  input  logic       place_valid,
  input  logic [7:0] place_addr,
  output logic [6:0] ship_cells,
  input  logic       shot_valid,
  input  logic [7:0] shot_addr,
  output logic       shot_ready,
  output logic       resp_valid,
  output logic [1:0] resp_code,
  input  logic       resp_ready,
  output logic [6:0] hits_taken,
  output logic       fleet_sunk,
  output logic       turn_grant,
  input  logic [7:0] disp_addr,
  output logic [1:0] disp_cell
);

  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, LOCKED} state_t;

  localparam logic [1:0] CODE_REJ  = 2'b00;
  localparam logic [1:0] CODE_MISS = 2'b01;
  localparam logic [1:0] CODE_HIT  = 2'b10;
  localparam logic [1:0] CODE_SUNK = 2'b11;
  localparam logic [6:0] SHIP_N    = 7'(SHIP_CELLS);

  state_t      state_q, state_d;
  logic [99:0] ship_map, shot_map;
  logic [7:0]  addr_q;
  logic [1:0]  lk_code;
  logic [6:0]  lk_idx, place_idx, disp_idx;
  logic        lk_in, lk_shot, lk_ship;
  logic        shot_acc, place_acc;

  function automatic logic in_range(input logic [7:0] a);
    return (a[7:4] < 4'd10) && (a[3:0] < 4'd10);
  endfunction

  function automatic logic [6:0] cell_idx(input logic [7:0] a);
    return {3'b000, a[7:4]} * 7'd10 + {3'b000, a[3:0]};
  endfunction

  assign resp_valid = (state_q == RESPOND);
  assign fleet_sunk = (hits_taken == SHIP_N);
  assign shot_acc   = shot_valid & shot_ready & (state_q == IDLE);
  // Placement only while disarmed and idle; never in the same cycle as an accepted shot.
  assign place_idx  = cell_idx(place_addr);
  assign place_acc  = place_valid & ~armed & (state_q == IDLE) & ~shot_acc & in_range(place_addr);

  assign lk_in   = in_range(addr_q);
  assign lk_idx  = cell_idx(addr_q);
  assign lk_shot = lk_in & shot_map[lk_idx];
  assign lk_ship = lk_in & ship_map[lk_idx];
  assign disp_idx = cell_idx(disp_addr);

  always_comb begin
    lk_code = CODE_REJ;
    if (lk_in) begin
      if (lk_shot || !lk_ship)                lk_code = CODE_MISS;
      else if (hits_taken + 7'd1 == SHIP_N)   lk_code = CODE_SUNK;
      else                                    lk_code = CODE_HIT;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (shot_acc) state_d = LOOKUP;
      LOOKUP:  state_d = RESPOND;
      RESPOND: if (resp_ready) state_d = (resp_code == CODE_SUNK) ? LOCKED : IDLE;
      LOCKED:  state_d = LOCKED;
      default: state_d = IDLE;
    endcase
    if (board_clear) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ship_map   <= '0;
      shot_map   <= '0;
      addr_q     <= '0;
      ship_cells <= '0;
      hits_taken <= '0;
      resp_code  <= CODE_REJ;
      shot_ready <= 1'b0;
      turn_grant <= 1'b0;
      disp_cell  <= 2'b00;
    end else begin
      state_q    <= state_d;
      shot_ready <= (state_d == IDLE) & armed;
      turn_grant <= resp_valid & resp_ready & (resp_code == CODE_MISS) & ~board_clear;
      disp_cell  <= in_range(disp_addr) ? {shot_map[disp_idx], ship_map[disp_idx]} : 2'b00;
      if (board_clear) begin
        ship_map   <= '0;
        shot_map   <= '0;
        ship_cells <= '0;
        hits_taken <= '0;
        resp_code  <= CODE_REJ;
      end else begin
        if (shot_acc) addr_q <= shot_addr;
        if (place_acc && !ship_map[place_idx]) begin
          ship_map[place_idx] <= 1'b1;
          ship_cells          <= ship_cells + 7'd1;
        end
        if (state_q == LOOKUP) begin
          resp_code <= lk_code;
          if (lk_in && !lk_shot) begin
            shot_map[lk_idx] <= 1'b1;
            if (lk_ship) hits_taken <= hits_taken + 7'd1;
          end
        end
      end
    end
  end

endmodule

// File: doc/shot_responder.md
# shot_responder

Defending side of the shot exchange between the two boards. It holds the local ship map and the received-shot map, and accepts incoming attack addresses from the link receiver; these are the same {row,col} bytes the opposing game controller drives on `check_out`. For each shot it returns a result code to the link transmitter, and the opponent's controller consumes that code as `msg_in`. It also counts hits taken, flags fleet destruction, grants the turn back after a miss, and exposes a registered read port for the board renderer.

## Interface
- `SHIP_CELLS`, default 11: number of ship cells in a full fleet. Fleet is sunk when the hit count reaches this value.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `board_clear` in 1: synchronous clear of both maps, both counters and the FSM; priority below `rst`.
- `armed` in 1: 0 = placement phase (writes allowed, shots refused); 1 = battle phase.
- `place_valid` in 1: write strobe, one ship cell.
- `place_addr` in 8: [7:4] row, [3:0] col.
- `ship_cells` out 7: number of distinct ship cells placed.
- `shot_valid` in 1: incoming shot present.
- `shot_addr` in 8: [7:4] row, [3:0] col.
- `shot_ready` out 1: shot is accepted on `shot_valid & shot_ready`.
- `resp_valid` out 1: result available.
- `resp_code` out 2: 00 reject, 01 miss, 10 hit, 11 fleet sunk.
- `resp_ready` in 1: transmitter accepts the result.
- `hits_taken` out 7: number of distinct ship cells hit.
- `fleet_sunk` out 1: level, high once `hits_taken == SHIP_CELLS`.
- `turn_grant` out 1: one-cycle pulse; local player now fires.
- `disp_addr` in 8: renderer read address.
- `disp_cell` out 2: {shot, ship} of the cell at `disp_addr`, one-cycle latency.

## Operation
- Board is 10x10, cell index = row*10 + col. An address with row > 9 or col > 9 is out of range.
- Storage: `ship_map[100]` and `shot_map[100]`, both flop arrays.
- Placement happens only when `armed`=0 and the FSM is in IDLE:
  - In-range `place_valid` sets the ship bit.
  - `ship_cells` increments only if the bit was previously 0.
  - Out-of-range addresses and writes while `armed`=1 are ignored.
- FSM states: IDLE, LOOKUP, RESPOND, LOCKED.
- IDLE:
  - `shot_ready` = `armed`.
  - On handshake, latch `shot_addr` and go to LOOKUP.
- LOOKUP, one cycle, classifies the latched address:
  - Out of range: code 00, no map change.
  - Cell already shot: code 01; maps and counters unchanged.
  - Fresh cell, no ship: code 01; set shot bit.
  - Fresh cell with ship: set shot bit and increment `hits_taken`. Code is 11 if the new count equals `SHIP_CELLS`, else 10.
  - Go to RESPOND.
- RESPOND:
  - `resp_valid`=1, `resp_code` stable until `resp_ready`.
  - On handshake with code 01: pulse `turn_grant`, go to IDLE.
  - On handshake with code 00 or 10: go to IDLE, no grant. The opponent keeps firing after a hit; a reject is re-sent.
  - On handshake with code 11: go to LOCKED.
- LOCKED: `shot_ready`=0 and `fleet_sunk`=1; leave only by `rst` or `board_clear`.
- `board_clear` in any state:
  - Zeroes both maps, `ship_cells` and `hits_taken`.
  - Drops `resp_valid` and goes to IDLE next cycle. Any pending response is discarded.
- Display port: `disp_cell` <= {shot_map[i], ship_map[i]} each cycle; 00 for an out-of-range `disp_addr`.

## Timing
- Reset values: `shot_ready`=0, `resp_valid`=0, `resp_code`=00, `turn_grant`=0, `fleet_sunk`=0, `hits_taken`=0, `ship_cells`=0, `disp_cell`=00; both maps cleared; state IDLE.
- `shot_ready` is registered; it rises the cycle after reset releases if `armed`=1.
- Shot handshake at edge T: LOOKUP during T+1; `resp_valid` high and the map/counter update visible from T+2. Minimum shot-to-shot period is 3 cycles with `resp_ready` held high.
- `turn_grant` is high the cycle after the miss handshake, for exactly one cycle.
- `fleet_sunk` rises together with `resp_valid` carrying code 11.
- `shot_valid` is ignored outside IDLE; no queuing.
- A `place_valid` in the same cycle as a shot is accepted only under the placement rule; since `armed` gates both, they never both succeed.
- `armed` falling mid-shot does not abort the exchange; it only blocks new acceptance.
- Counters cannot wrap: `hits_taken` ≤ `SHIP_CELLS`, and `ship_cells` ≤ 100 because it counts only new bits.

## Test plan
- Place cells 0x00, 0x01, 0x00 with `armed`=0 -> `ship_cells`=2; `disp_addr`=0x00 gives `disp_cell`=01 one cycle later.
- `armed`=1, shot 0x55 on an empty cell, `resp_ready`=1 -> `resp_code`=01 at T+2, `turn_grant` pulse at T+3, `hits_taken`=0.
- Shot 0x01 on a ship cell, `resp_ready` held low 5 cycles -> `resp_valid`/10 held stable 5 cycles, `hits_taken`=1, no `turn_grant`. Repeat 0x01 -> 01, `hits_taken` unchanged.
- Shot 0xA3 -> code 00, maps unchanged, no grant, back to IDLE.
- With `SHIP_CELLS`=2, hit 0x00 then 0x01 -> second code 11, `fleet_sunk`=1, `shot_ready` stays 0 under further `shot_valid`.
- `board_clear` asserted in RESPOND -> `resp_valid` 0 next cycle, counters 0, `disp_cell`=00 for all cells, `shot_ready`=1.
